// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with optional first-word-fall-through
// read, programmable almost-full/almost-empty thresholds, an occupancy
// count and sticky overflow/underflow flags.
//
// FIFO state is {count, wr_ptr, rd_ptr}. Flags decode from the registered
// count, so write acceptance never depends on a read in the same cycle
// (and vice versa).
module sync_fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new offending request wins over a clear in the same cycle.
    if (wr_en & full)  ovf_d = 1'b1;
    else if (err_clr)  ovf_d = 1'b0;
    if (rd_en & empty) unf_d = 1'b1;
    else if (err_clr)  unf_d = 1'b0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; deliberately not reset, contents are tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;
      // Registered read: load the head word on each accepted pop.
      always_ff @(posedge clk) begin
        if (rst)         rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-read and an FWFT instance share one
// stimulus stream; a queue model predicts every output each cycle.
module tb_sync_fifo_flex;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst, wr_en, rd_en, err_clr;
  logic [W-1:0] wr_data;

  logic [W-1:0] rd_s, rd_f;
  logic         emp_s, ful_s, af_s, ae_s, ovf_s, unf_s;
  logic         emp_f, ful_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0]   cnt_s, cnt_f;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_s), .empty(emp_s), .full(ful_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(cnt_s), .overflow(ovf_s), .underflow(unf_s),
    .err_clr(err_clr));

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_f), .empty(emp_f), .full(ful_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(unf_f),
    .err_clr(err_clr));

  // Reference model: a queue of stored words plus the sticky flags and the
  // last word popped (what a registered read port shows).
  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_rd;

  always @(posedge clk) begin
    bit was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd  = '0;
    end else begin
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      if (rd_en && !was_empty) m_rd = mq.pop_front();
      if (wr_en && !was_full)  mq.push_back(wr_data);
      if (wr_en && was_full)   m_ovf = 1'b1;
      else if (err_clr)        m_ovf = 1'b0;
      if (rd_en && was_empty)  m_unf = 1'b1;
      else if (err_clr)        m_unf = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = mq.size();
      chk("count_s", cnt_s, n);
      chk("count_f", cnt_f, n);
      chk("empty_s", emp_s, n == 0);
      chk("empty_f", emp_f, n == 0);
      chk("full_s",  ful_s, n == D);
      chk("full_f",  ful_f, n == D);
      chk("afull_s", af_s, n >= AF);
      chk("afull_f", af_f, n >= AF);
      chk("aempty_s", ae_s, n <= AE);
      chk("aempty_f", ae_f, n <= AE);
      chk("ovf_s", ovf_s, m_ovf);
      chk("ovf_f", ovf_f, m_ovf);
      chk("unf_s", unf_s, m_unf);
      chk("unf_f", unf_f, m_unf);
      chk("rd_std", rd_s, m_rd);
      chk("rd_fwft", rd_f, (n == 0) ? 0 : mq[0]);
    end
  end

  // Apply one cycle of inputs; returns just after the edge that samples them.
  task automatic drive(input bit w, input logic [W-1:0] d, input bit r,
                       input bit ec, input bit rs);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    err_clr = ec;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw, pr;
    logic [W-1:0] pat;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;

    // 1: reset, then 17 writes of 0x01..0x11
    drive(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", cnt_s, 0);
    chk("rst_empty", emp_s, 1);
    chk("rst_aempty", ae_f, 1);
    chk("rst_rd_std", rd_s, 0);
    chk("rst_rd_fwft", rd_f, 0);
    for (int i = 1; i <= 17; i++) begin
      drive(1, W'(i), 0, 0, 0);
      if (i == 13) chk("af_at13", af_s, 0);
      if (i == 14) chk("af_at14", af_s, 1);
      if (i == 16) chk("full_at16", ful_s, 1);
    end
    chk("t1_count", cnt_s, 16);
    chk("t1_ovf", ovf_s, 1);

    // 2: 17 reads, registered data one cycle after rd_en
    for (int i = 1; i <= 17; i++) begin
      drive(0, 0, 1, 0, 0);
      if (i <= 16) chk("t2_rd_std", rd_s, i);
      if (i == 14) chk("t2_aempty", ae_s, 1);
    end
    chk("t2_unf", unf_s, 1);
    chk("t2_rd_hold", rd_s, 8'h10);
    drive(0, 0, 0, 1, 0);
    chk("t2_clr", ovf_s | unf_s, 0);

    // 3: FWFT fall-through of 0xA5
    drive(1, 8'hA5, 0, 0, 0);
    chk("t3_fall", rd_f, 8'hA5);
    drive(0, 0, 0, 0, 0);
    chk("t3_hold", rd_f, 8'hA5);
    drive(0, 0, 1, 0, 0);
    chk("t3_empty", emp_f, 1);
    chk("t3_rd0", rd_f, 0);

    // 4: fill to 8, then 50 simultaneous write/read cycles across wrap
    for (int i = 0; i < 8; i++) drive(1, W'(8'h20 + i), 0, 0, 0);
    pat = 8'h28;
    for (int i = 0; i < 50; i++) begin
      drive(1, pat, 1, 0, 0);
      pat++;
    end
    chk("t4_count", cnt_s, 8);
    chk("t4_last_rd", rd_s, 8'h20 + 8'd49);

    // 5: full boundary and error-clear precedence
    for (int i = 0; i < 8; i++) drive(1, W'(8'h70 + i), 0, 0, 0);
    chk("t5_full", ful_s, 1);
    drive(1, 8'hEE, 1, 0, 0);
    chk("t5_count15", cnt_s, 15);
    chk("t5_ovf", ovf_s, 1);
    drive(1, 8'h80, 0, 0, 0);
    drive(1, 8'h81, 0, 1, 0);
    chk("t5_set_wins", ovf_s, 1);
    drive(0, 0, 0, 1, 0);
    chk("t5_cleared", ovf_s, 0);

    // 6: reset mid-stream at count=10 with wr_en high
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, W'(8'h40 + i), 0, 0, 0);
    chk("t6_count10", cnt_s, 10);
    drive(1, 8'h99, 0, 0, 1);
    chk("t6_count0", cnt_s, 0);
    chk("t6_empty", emp_f, 1);
    drive(1, 8'h3C, 0, 0, 0);
    chk("t6_fwft", rd_f, 8'h3C);
    drive(0, 0, 1, 0, 0);
    chk("t6_std", rd_s, 8'h3C);
    chk("t6_empty2", emp_s, 1);

    // Random phases with varying write/read bias and occasional reset
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pr = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 250; i++) begin
        drive($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < pr,
              $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      end
    end

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, the next-generation replacement for the basic synchronous FIFO in the shared buffer library. It adds:
- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- sticky overflow and underflow error flags.

It sits between any producer/consumer pair in one clock domain, e.g. datapath-to-DMA staging and command queues.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥4.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write word.
- rd_en  in  1  read (pop) request.
- rd_data  out  WIDTH  read word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow and underflow.

## Operation
- Storage: DEPTH×WIDTH register array, not reset.
- Pointers: wr_ptr and rd_ptr, $clog2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
- Accepted write: wr_acc = wr_en & ~full. Stores wr_data at wr_ptr and increments wr_ptr.
- Accepted read: rd_acc = rd_en & ~empty. Increments rd_ptr.
- Acceptance is decided on the registered flags only:
  - a write while full is rejected even if a read is accepted the same cycle;
  - a read while empty is rejected even if a write is accepted the same cycle.
- Count update: count_next = count + wr_acc − rd_acc. A simultaneous accepted read and write leaves count unchanged.
- Standard mode (FWFT=0): on rd_acc, rd_data is loaded from mem[rd_ptr] at the same edge. Otherwise rd_data holds its last value.
- FWFT mode (FWFT=1): rd_data = empty ? 0 : mem[rd_ptr], combinational from registered state. rd_en acknowledges and pops the displayed word.
- Flags: empty, full, almost_full and almost_empty decode combinationally from the registered count. There is no other state machine; the FIFO state is {count, pointers}.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both clear on err_clr. Set wins over err_clr in the same cycle.
  - Rejected operations change no other state.
- Reset: rst dominates wr_en, rd_en and err_clr in the same cycle. A reset mid-operation discards all contents.

## Timing
- Reset values: count=0, empty=1, almost_empty=1 (AE_LEVEL ≥ 0), full=0, almost_full=0, overflow=0, underflow=0, rd_data=0, both pointers 0.
- Write-to-flag latency: empty deasserts and count increments at the edge that accepts the write, visible the following cycle.
- Write-to-read latency:
  - FWFT=1: a word written into an empty FIFO appears on rd_data one cycle after wr_en is sampled.
  - FWFT=0: the word is readable from that cycle on; rd_data is valid one cycle after rd_en is sampled.
- Throughput: one write and one read per cycle, sustained.
- Full boundary: at count==DEPTH, wr_en & rd_en pops one word and rejects the write (count → DEPTH−1). Overflow sets.
- Empty boundary: at count==0, wr_en & rd_en pushes the word and rejects the read (count → 1). Underflow sets.
- Error-flag timing: overflow and underflow assert the cycle after the offending request and stay high until err_clr.

## Test plan
1. Reset, then 17 single-cycle writes of 0x01..0x11 (DEPTH=16):
   - count reaches 16 and full=1;
   - almost_full rises when count reaches 14;
   - the 17th write sets overflow;
   - count stays 16.
2. FWFT=0, then 17 reads:
   - rd_data returns 0x01..0x10 in order, each one cycle after rd_en;
   - almost_empty=1 once count ≤ 2;
   - the 17th read sets underflow, and rd_data holds 0x10.
3. FWFT=1, write 0xA5 into the empty FIFO:
   - rd_data=0xA5 the next cycle with no rd_en;
   - rd_en pops it, after which empty=1 and rd_data=0.
4. Fill to 8, then 50 cycles of simultaneous wr_en/rd_en with an incrementing pattern:
   - count stays 8;
   - output order matches input order across pointer wrap.
5. Full plus simultaneous wr_en/rd_en: count 16→15, overflow=1. Then assert err_clr together with a new wr_en while full: overflow stays 1. Then err_clr alone: overflow clears.
6. Reset asserted mid-stream with count=10 and wr_en=1:
   - the next cycle shows count=0, empty=1, all flags at reset values;
   - a subsequent write/read round-trips the new word only.
